// File: rtl/spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) behind the LSU SPI CSR; build with SPI_LOOPBACK_EN to loop MOSI into the receive path.
// Latency: busy rises 1 cycle after the trigger edge and stays high 16*CLK_DIV cycles; response updates as busy falls.
// Backpressure: none queued; trigger edges arriving while busy are dropped, so software must wait for busy=0.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_trigger,
    input  logic [7:0] spi_command,
    input  logic       spi_cs_ctrl,
    output logic       spi_busy,
    output logic [7:0] spi_response,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          trig_q;
    logic          start;
    logic          load;
    logic          done;
    logic          phase_evt;
    logic          rx_in;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    assign start     = spi_trigger & ~trig_q;
    assign phase_evt = (state_q == SHIFT) && (div_cnt == DIV_MAX);

`ifdef SPI_LOOPBACK_EN
    // Loopback: the pin is ignored and the byte on MOSI is captured instead.
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_in       = spi_mosi;
`else
    assign rx_in = spi_miso;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus load/complete strobes for the datapath.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Last falling edge of the byte ends the transfer.
                if (phase_evt && spi_sclk && (bit_cnt == 3'd7)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Trigger edge history and registered chip-select pass-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q <= 1'b0;
            spi_cs <= 1'b1;
        end else begin
            trig_q <= spi_trigger;
            spi_cs <= spi_cs_ctrl;
        end
    end

    // Shift datapath: sample on rising SCLK, shift out on falling SCLK.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_busy     <= 1'b0;
            spi_response <= 8'h00;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= 3'd0;
            tx_sr        <= 8'h00;
            rx_sr        <= 8'h00;
        end else if (load) begin
            tx_sr    <= spi_command;
            spi_mosi <= spi_command[7];
            bit_cnt  <= 3'd0;
            div_cnt  <= '0;
            spi_busy <= 1'b1;
        end else if (state_q == SHIFT) begin
            if (phase_evt) begin
                div_cnt <= '0;
                if (!spi_sclk) begin
                    spi_sclk <= 1'b1;
                    rx_sr    <= {rx_sr[6:0], rx_in};
                end else begin
                    spi_sclk <= 1'b0;
                    if (done) begin
                        spi_response <= rx_sr;
                        spi_busy     <= 1'b0;
                        spi_mosi     <= 1'b0;
                    end else begin
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        spi_mosi <= tx_sr[6];
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule
